// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter sequencing block.
//   state_e      - controller state encoding (IDLE, RUN, DONE), 2 bits
//   DEF_WIDTH    - default count / modulus width
//   DEF_REP_W    - default repeat-count / pass-counter width
// Optional feature macro used by the block: COUNTER_SCHED_DOWN_EN.
package counter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/counter_core.sv
// counter_core: WIDTH-bit count register for the sequencing controller.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   en          - step the count by one
//   clr         - force count to zero (highest priority)
//   load        - load load_val (priority over en)
//   load_val    - value used by load
//   dir         - (COUNTER_SCHED_DOWN_EN only) 1 = decrement, 0 = increment
//   count       - registered count value
// Arithmetic wraps modulo 2^WIDTH.
module counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SCHED_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
`ifdef COUNTER_SCHED_DOWN_EN
            count_d = dir ? (count_q - ONE) : (count_q + ONE);
`else
            count_d = count_q + ONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sched.sv
// counter_sched: sequencing controller for a bounded, repeatable count.
// A start in IDLE samples modulus and reps; the counter then steps through
// 0..modulus once per pass for reps passes (reps=0 runs one pass).
// Ports:
//   clk, reset - rising-edge clock, synchronous active-high reset
//   start      - begin a run (only honoured in IDLE, and not with stop)
//   stop       - abort the current run, back to IDLE without done
//   pause      - level; freezes count, pass counter and wrap while in RUN
//   modulus    - terminal count, sampled on accepted start
//   reps       - number of passes, sampled on accepted start
//   dir        - (COUNTER_SCHED_DOWN_EN only) 1 = count down from modulus
//   count      - current count
//   pass_cnt   - completed passes in the current run
//   busy       - state is RUN
//   wrap       - one-cycle pulse per completed pass
//   done       - one-cycle pulse when the final pass completes
// Optional feature macro: COUNTER_SCHED_DOWN_EN adds down counting.
module counter_sched
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] modulus,
    input  logic [REP_W-1:0] reps,
`ifdef COUNTER_SCHED_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic [REP_W-1:0] pass_cnt,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_e           state_q, state_d;
    logic [REP_W-1:0] pass_q,  pass_d;
    logic [WIDTH-1:0] mod_q,   mod_d;
    logic [REP_W-1:0] reps_q,  reps_d;
    logic             wrap_q,  wrap_d;
`ifdef COUNTER_SCHED_DOWN_EN
    logic             dir_q,   dir_d;
`endif

    logic             core_en;
    logic             core_clr;
    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic [WIDTH-1:0] count_w;
    logic             at_term;
    logic             last_pass;

    // A pass ends on the terminal value: mod_q when counting up, 0 when down.
`ifdef COUNTER_SCHED_DOWN_EN
    assign at_term = dir_q ? (count_w == '0) : (count_w == mod_q);
`else
    assign at_term = (count_w == mod_q);
`endif
    assign last_pass = (pass_q == (reps_q - REP_ONE));

    always_comb begin
        state_d       = state_q;
        pass_d        = pass_q;
        mod_d         = mod_q;
        reps_d        = reps_q;
        wrap_d        = 1'b0;
`ifdef COUNTER_SCHED_DOWN_EN
        dir_d         = dir_q;
`endif
        core_en       = 1'b0;
        core_clr      = 1'b0;
        core_load     = 1'b0;
        core_load_val = mod_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    pass_d  = '0;
                    mod_d   = modulus;
                    reps_d  = (reps == '0) ? REP_ONE : reps;
`ifdef COUNTER_SCHED_DOWN_EN
                    dir_d   = dir;
                    // Down runs begin at the live modulus, not the stale mod_q.
                    if (dir) begin
                        core_load     = 1'b1;
                        core_load_val = modulus;
                    end else begin
                        core_clr = 1'b1;
                    end
`else
                    core_clr = 1'b1;
`endif
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    pass_d   = '0;
                    core_clr = 1'b1;
                end else if (!pause) begin
                    if (at_term) begin
                        wrap_d = 1'b1;
`ifdef COUNTER_SCHED_DOWN_EN
                        if (dir_q) begin
                            core_load = 1'b1;
                        end else begin
                            core_clr = 1'b1;
                        end
`else
                        core_clr = 1'b1;
`endif
                        if (last_pass) begin
                            state_d = ST_DONE;
                        end else begin
                            pass_d = pass_q + REP_ONE;
                        end
                    end else begin
                        core_en = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Single-cycle state; start here is deliberately ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            mod_q   <= '0;
            reps_q  <= REP_ONE;
            wrap_q  <= 1'b0;
`ifdef COUNTER_SCHED_DOWN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            mod_q   <= mod_d;
            reps_q  <= reps_d;
            wrap_q  <= wrap_d;
`ifdef COUNTER_SCHED_DOWN_EN
            dir_q   <= dir_d;
`endif
        end
    end

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (core_en),
        .clr      (core_clr),
        .load     (core_load),
        .load_val (core_load_val),
`ifdef COUNTER_SCHED_DOWN_EN
        .dir      (dir_q),
`endif
        .count    (count_w)
    );

    assign count    = count_w;
    assign pass_cnt = pass_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: self-checking bench for counter_sched.
// A behavioural reference model predicts the outputs after every clock
// edge; the prediction is queued before the edge and popped and compared
// one time unit after it. Directed checks from the expected timing are
// layered on top. Handshake: inputs change 1 time unit after a rising edge
// and are sampled by the DUT at the next rising edge.
module tb_counter_sched;

    localparam int W     = 4;
    localparam int R     = 4;
    localparam int VEC_W = W + R + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start;
    logic         stop;
    logic         pause;
    logic [W-1:0] modulus;
    logic [R-1:0] reps;
    logic         dir;
    logic [W-1:0] count;
    logic [R-1:0] pass_cnt;
    logic         busy;
    logic         wrap;
    logic         done;

    counter_sched #(.WIDTH(W), .REP_W(R)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .modulus  (modulus),
        .reps     (reps),
`ifdef COUNTER_SCHED_DOWN_EN
        .dir      (dir),
`endif
        .count    (count),
        .pass_cnt (pass_cnt),
        .busy     (busy),
        .wrap     (wrap),
        .done     (done)
    );

    // ---------------- scoreboard ----------------
    logic [VEC_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_state = 0; // 0 idle, 1 run, 2 done
    logic [W-1:0] m_count = '0;
    logic [R-1:0] m_pass  = '0;
    logic [W-1:0] m_mod   = '0;
    logic [R-1:0] m_reps  = 4'd1;
    logic         m_wrap  = 1'b0;
    logic         m_dir   = 1'b0;

    function automatic logic dir_eff();
`ifdef COUNTER_SCHED_DOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        logic term;
        if (reset) begin
            m_state = 0; m_count = '0; m_pass = '0; m_mod = '0;
            m_reps = 4'd1; m_wrap = 1'b0; m_dir = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    m_wrap = 1'b0;
                    if (start && !stop) begin
                        m_state = 1;
                        m_pass  = '0;
                        m_mod   = modulus;
                        m_reps  = (reps == 4'd0) ? 4'd1 : reps;
                        m_dir   = dir_eff();
                        m_count = m_dir ? modulus : 4'd0;
                    end
                end
                1: begin
                    if (stop) begin
                        m_state = 0; m_count = '0; m_pass = '0; m_wrap = 1'b0;
                    end else if (pause) begin
                        m_wrap = 1'b0;
                    end else begin
                        term = m_dir ? (m_count == 4'd0) : (m_count == m_mod);
                        if (term) begin
                            m_wrap  = 1'b1;
                            m_count = m_dir ? m_mod : 4'd0;
                            if (m_pass == m_reps - 4'd1) m_state = 2;
                            else m_pass = m_pass + 4'd1;
                        end else begin
                            m_wrap  = 1'b0;
                            m_count = m_dir ? (m_count - 4'd1) : (m_count + 4'd1);
                        end
                    end
                end
                default: begin
                    m_state = 0;
                    m_wrap  = 1'b0;
                end
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [VEC_W-1:0] exp_v;
        logic [VEC_W-1:0] obs_v;
        model_step();
        exp_q.push_back({m_count, m_pass, m_state == 1, m_wrap, m_state == 2});
        @(posedge clk);
        #1;
        obs_v = {count, pass_cnt, busy, wrap, done};
        exp_v = exp_q.pop_front();
        check("outputs", 32'(obs_v), 32'(exp_v));
    endtask

    task automatic start_run(input logic [W-1:0] m, input logic [R-1:0] r, input logic d);
        start = 1'b1; modulus = m; reps = r; dir = d;
        tick();
        start = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        modulus = '0; reps = '0; dir = 1'b0;
        @(posedge clk); #1;
        idle_ticks(2);
        check("reset_state", 32'({count, pass_cnt, busy, wrap, done}), 32'd0);
        reset = 1'b0;
        idle_ticks(2);

        // Basic run: modulus 3, two passes.
        start_run(4'd3, 4'd2, 1'b0);
        check("basic_count0", 32'(count), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i <= 8) check("basic_count", 32'(count), 32'(i % 4));
            check("basic_wrap", 32'(wrap), 32'((i == 4) || (i == 8)));
            check("basic_done", 32'(done), 32'(i == 8));
            if (i == 5) check("basic_pass", 32'(pass_cnt), 32'd1);
        end
        check("basic_busy_end", 32'(busy), 32'd0);
        idle_ticks(2);

        // Reset held 3 cycles mid-run, then a normal run.
        start_run(4'd5, 4'd3, 1'b0);
        idle_ticks(4);
        reset = 1'b1;
        idle_ticks(3);
        reset = 1'b0;
        check("midreset_out", 32'({count, pass_cnt, busy, wrap, done}), 32'd0);
        start_run(4'd1, 4'd1, 1'b0);
        idle_ticks(4);

        // Pause for 2 cycles at count 2: done slips from E+4 to E+6.
        start_run(4'd3, 4'd1, 1'b0);
        idle_ticks(2);
        check("pause_at2", 32'(count), 32'd2);
        pause = 1'b1;
        idle_ticks(2);
        check("pause_hold", 32'(count), 32'd2);
        pause = 1'b0;
        k = 4;
        while (!done && k < 30) begin
            tick();
            k++;
        end
        check("pause_done_edge", 32'(k), 32'd6);
        idle_ticks(2);

        // Stop at count 1: back to IDLE, no done.
        start_run(4'd4, 4'd2, 1'b0);
        tick();
        check("stop_at1", 32'(count), 32'd1);
        stop = 1'b1;
        pause = 1'b1;
        tick();
        stop = 1'b0;
        pause = 1'b0;
        check("stop_busy", 32'({busy, done, count}), 32'd0);
        idle_ticks(3);

        // modulus 0, reps 0: wrap and done one edge after start.
        start_run(4'd0, 4'd0, 1'b0);
        tick();
        check("m0_wrap_done", 32'({wrap, done}), 32'b11);
        idle_ticks(2);

        // start together with stop in IDLE.
        start = 1'b1; stop = 1'b1; modulus = 4'd3; reps = 4'd1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(busy), 32'd0);
        idle_ticks(1);

        // start held during RUN with new operands: ignored.
        start_run(4'd3, 4'd2, 1'b0);
        start = 1'b1; modulus = 4'd9; reps = 4'd5;
        idle_ticks(4);
        check("start_in_run", 32'({count, pass_cnt}), 32'({4'd0, 4'd1}));
        start = 1'b0;
        idle_ticks(6);

`ifdef COUNTER_SCHED_DOWN_EN
        // Down mode: 2,1,0,2 with wrap and done on the reload edge.
        start_run(4'd2, 4'd1, 1'b1);
        check("down_c0", 32'(count), 32'd2);
        tick();
        check("down_c1", 32'(count), 32'd1);
        tick();
        check("down_c2", 32'(count), 32'd0);
        tick();
        check("down_reload", 32'({count, wrap, done}), 32'({4'd2, 1'b1, 1'b1}));
        dir = 1'b0;
        idle_ticks(2);
`endif

        // Random traffic, checked against the model every cycle.
        for (int i = 0; i < 500; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 19) == 0);
            pause   = ($urandom_range(0, 5) == 0);
            modulus = W'($urandom_range(0, 7));
            reps    = R'($urandom_range(0, 3));
            dir     = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
